// File: rtl/aes_pkg.sv
// Shared AES/Rijndael state-layout helpers.
// State is row-major, 4 rows x nb columns, with byte (0,0) in the MSB byte.
package aes_pkg;

  localparam int unsigned STATE_ROWS = 4;
  localparam int unsigned BYTE_W     = 8;

  typedef enum logic {
    SHIFT_FWD = 1'b0,
    SHIFT_INV = 1'b1
  } shift_mode_e;

  // Rijndael row rotation amount; 256-bit blocks use wider offsets on rows 2 and 3.
  function automatic int unsigned row_offset(input int unsigned nb, input int unsigned r);
    if (nb == 8) begin
      case (r)
        0:       return 0;
        1:       return 1;
        2:       return 3;
        default: return 4;
      endcase
    end
    return r;
  endfunction

  function automatic int unsigned byte_lsb(input int unsigned nb, input int unsigned r,
                                           input int unsigned c);
    return BYTE_W * (STATE_ROWS * nb - 1 - (r * nb + c));
  endfunction

endpackage

// File: rtl/shiftrows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for an NB-column state.
// Pure wiring, so it can be dropped into both iterative and unrolled datapaths.
module shiftrows_perm
  import aes_pkg::*;
#(
  parameter int unsigned NB = 4
) (
  input  logic [32*NB-1:0] in_data,
  input  logic             inv,
  output logic [32*NB-1:0] out_data
);

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shiftrows_perm: NB must be 4, 6 or 8");
  end

  shift_mode_e mode;
  assign mode = shift_mode_e'(inv);

  for (genvar r = 0; r < STATE_ROWS; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int unsigned Off    = row_offset(NB, r);
      localparam int unsigned FwdSrc = (c + Off) % NB;
      localparam int unsigned InvSrc = (c + NB - Off) % NB;

      assign out_data[byte_lsb(NB, r, c) +: BYTE_W] = (mode == SHIFT_INV)
          ? in_data[byte_lsb(NB, r, InvSrc) +: BYTE_W]
          : in_data[byte_lsb(NB, r, FwdSrc) +: BYTE_W];
    end
  end

endmodule

// File: rtl/shiftrows_pipe.sv
// Registered ShiftRows stage: rotation feeds an elastic valid/ready pipeline of
// PIPE_STAGES slices carrying a sideband tag alongside the state.
module shiftrows_pipe
  import aes_pkg::*;
#(
  parameter int unsigned NB          = 4,
  parameter int unsigned PIPE_STAGES = 1,
  parameter int unsigned TAG_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [32*NB-1:0]   in_data,
  input  logic               in_inv,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [32*NB-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned W = 32 * NB;

  if (!(PIPE_STAGES == 1 || PIPE_STAGES == 2)) begin : g_bad_stages
    $error("shiftrows_pipe: PIPE_STAGES must be 1 or 2");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("shiftrows_pipe: TAG_W must be at least 1");
  end

  logic [W-1:0] perm_data;

  shiftrows_perm #(
    .NB(NB)
  ) u_perm (
    .in_data (in_data),
    .inv     (in_inv),
    .out_data(perm_data)
  );

  logic [PIPE_STAGES-1:0] valid_q;
  logic [PIPE_STAGES-1:0] advance;
  logic [W-1:0]           data_q [PIPE_STAGES];
  logic [TAG_W-1:0]       tag_q  [PIPE_STAGES];

  // advance[i]: stage i empties or hands its beat on at the coming edge.
  always_comb begin
    advance = '0;
    advance[PIPE_STAGES-1] = out_ready;
    for (int i = PIPE_STAGES - 2; i >= 0; i--) begin
      advance[i] = !valid_q[i+1] || advance[i+1];
    end
  end

  assign in_ready = !clear && (!valid_q[0] || advance[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else if (clear) begin
      // Flush only the valid bits; payload registers become don't-care.
      valid_q <= '0;
    end else begin
      if (in_ready) begin
        valid_q[0] <= in_valid;
        if (in_valid) begin
          data_q[0] <= perm_data;
          tag_q[0]  <= in_tag;
        end
      end
      for (int i = 1; i < PIPE_STAGES; i++) begin
        if (advance[i-1]) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) begin
            data_q[i] <= data_q[i-1];
            tag_q[i]  <= tag_q[i-1];
          end
        end
      end
    end
  end

  assign out_valid = valid_q[PIPE_STAGES-1];
  assign out_data  = data_q[PIPE_STAGES-1];
  assign out_tag   = tag_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_shiftrows_pipe.sv
// Self-checking bench for shiftrows_pipe: fixed vectors for NB = 4/6/8, random
// streams against a byte-array reference model, and clear/reset corner cases.
module tb_shiftrows_pipe;

  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_inv = 1'b0;
  logic             out_ready = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [127:0]     in_data4 = '0;
  logic [191:0]     in_data6 = '0;
  logic [255:0]     in_data8 = '0;

  logic             in_ready4, out_valid4, in_ready6, out_valid6, in_ready8, out_valid8;
  logic [127:0]     out_data4;
  logic [191:0]     out_data6;
  logic [255:0]     out_data8;
  logic [TAG_W-1:0] out_tag4, out_tag6, out_tag8;

  always #5 clk = ~clk;

  shiftrows_pipe #(.NB(4), .PIPE_STAGES(2), .TAG_W(TAG_W)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data4), .in_inv(in_inv), .in_tag(in_tag), .out_valid(out_valid4),
    .out_ready(out_ready), .out_data(out_data4), .out_tag(out_tag4)
  );

  shiftrows_pipe #(.NB(6), .PIPE_STAGES(1), .TAG_W(TAG_W)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready6),
    .in_data(in_data6), .in_inv(in_inv), .in_tag(in_tag), .out_valid(out_valid6),
    .out_ready(out_ready), .out_data(out_data6), .out_tag(out_tag6)
  );

  shiftrows_pipe #(.NB(8), .PIPE_STAGES(1), .TAG_W(TAG_W)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready8),
    .in_data(in_data8), .in_inv(in_inv), .in_tag(in_tag), .out_valid(out_valid8),
    .out_ready(out_ready), .out_data(out_data8), .out_tag(out_tag8)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Scoreboard for the NB=4 pipe: expected beats in flight, oldest first.
  logic [127:0]     q_data [$];
  logic [TAG_W-1:0] q_tag  [$];
  bit               mon_en = 1'b0;
  bit               acc = 1'b0;
  bit               stall_prev = 1'b0;
  logic [127:0]     hold_data = '0;
  logic [TAG_W-1:0] hold_tag = '0;
  int               emitted = 0;

  typedef struct {
    int               nb;
    bit               inv;
    logic [TAG_W-1:0] tag;
    logic [255:0]     din;
    logic [255:0]     dexp;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [255:0] ref_shift(input int nb, input logic [255:0] d,
                                             input bit inv);
    logic [7:0]   b [4][8];
    logic [255:0] res;
    int           off [4];
    int           src;
    res = '0;
    off[0] = 0;
    off[1] = 1;
    off[2] = (nb == 8) ? 3 : 2;
    off[3] = (nb == 8) ? 4 : 3;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++)
        b[r][c] = d[8*(4*nb-1-(r*nb+c)) +: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++) begin
        src = inv ? (c - off[r] + nb) % nb : (c + off[r]) % nb;
        res[8*(4*nb-1-(r*nb+c)) +: 8] = b[r][src];
      end
    return res;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: observe handshakes at the falling edge, return 1 time unit after rising.
  task automatic tick();
    logic [255:0] tmp;
    @(negedge clk);
    acc = rst_n && !clear && in_valid && in_ready4;
    if (mon_en && rst_n) begin
      if (stall_prev) begin
        chk("stall_valid", out_valid4, 1);
        chk("stall_data", out_data4, hold_data);
        chk("stall_tag", out_tag4, hold_tag);
      end
      chk("in_ready_rule", in_ready4, !clear && !(q_data.size() == 2 && !out_ready));
      if (out_valid4 && out_ready) begin
        emitted++;
        if (q_data.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got tag %0h expected no beat", out_tag4);
        end else begin
          chk("out_data", out_data4, q_data.pop_front());
          chk("out_tag", out_tag4, q_tag.pop_front());
        end
      end
      if (acc) begin
        tmp = ref_shift(4, {128'b0, in_data4}, in_inv);
        q_data.push_back(tmp[127:0]);
        q_tag.push_back(in_tag);
      end
      stall_prev = out_valid4 && !out_ready;
      hold_data  = out_data4;
      hold_tag   = out_tag4;
      if (clear) begin
        q_data.delete();
        q_tag.delete();
        stall_prev = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_recv(input logic [127:0] d, input bit inv, input logic [TAG_W-1:0] tag,
                           output logic [127:0] res);
    int budget;
    in_valid  = 1'b1;
    in_data4  = d;
    in_inv    = inv;
    in_tag    = tag;
    out_ready = 1'b1;
    acc = 1'b0;
    budget = 0;
    while (!acc && budget < 20) begin
      tick();
      budget++;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_accept_timeout", 0, 1);
    budget = 0;
    while (!out_valid4 && budget < 20) begin
      tick();
      budget++;
    end
    if (!out_valid4) chk("recv_timeout", 0, 1);
    res = out_data4;
    tick();
  endtask

  task automatic stream(input int n, input int ready_pct, input bit hold_valid);
    int idx;
    int budget;
    idx = 0;
    budget = 0;
    emitted = 0;
    while ((idx < n || q_data.size() > 0) && budget < 50 * n + 50) begin
      in_valid  = (idx < n) && (hold_valid || $urandom_range(0, 99) < 70);
      in_data4  = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_inv    = $urandom_range(0, 1);
      in_tag    = TAG_W'(idx);
      out_ready = $urandom_range(0, 99) < ready_pct;
      tick();
      if (acc) idx++;
      budget++;
    end
    in_valid = 1'b0;
    chk("stream_emitted", emitted, n);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    logic [127:0] s, f, g;

    vecs[0] = '{4, 1'b0, 4'h3, 256'h00010203_04050607_08090A0B_0C0D0E0F,
                256'h00010203_05060704_0A0B0809_0F0C0D0E};
    vecs[1] = '{4, 1'b1, 4'h5, 256'h00010203_05060704_0A0B0809_0F0C0D0E,
                256'h00010203_04050607_08090A0B_0C0D0E0F};
    vecs[2] = '{8, 1'b0, 4'h6,
                256'h0001020304050607_08090A0B0C0D0E0F_1011121314151617_18191A1B1C1D1E1F,
                256'h0001020304050607_090A0B0C0D0E0F08_1314151617101112_1C1D1E1F18191A1B};
    vecs[3] = '{8, 1'b1, 4'h7,
                256'h0001020304050607_090A0B0C0D0E0F08_1314151617101112_1C1D1E1F18191A1B,
                256'h0001020304050607_08090A0B0C0D0E0F_1011121314151617_18191A1B1C1D1E1F};
    vecs[4] = '{6, 1'b0, 4'h8, 256'h000102030405_08090A0B0C0D_101112131415_18191A1B1C1D,
                256'h000102030405_090A0B0C0D08_121314151011_1B1C1D18191A};
    vecs[5] = '{6, 1'b1, 4'h9, 256'h000102030405_090A0B0C0D08_121314151011_1B1C1D18191A,
                256'h000102030405_08090A0B0C0D_101112131415_18191A1B1C1D};

    // Reset state.
    #2;
    chk("rst_out_valid", out_valid4, 0);
    chk("rst_out_data", out_data4, 0);
    chk("rst_out_tag", out_tag4, 0);
    chk("rst_in_ready", in_ready4, 1);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Fixed vectors for each block width.
    foreach (vecs[i]) begin
      in_valid  = 1'b1;
      in_inv    = vecs[i].inv;
      in_tag    = vecs[i].tag;
      out_ready = 1'b1;
      in_data4  = vecs[i].din[127:0];
      in_data6  = vecs[i].din[191:0];
      in_data8  = vecs[i].din;
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_accept", i), acc, 1);
      case (vecs[i].nb)
        8: begin
          chk($sformatf("vec%0d_valid", i), out_valid8, 1);
          chk($sformatf("vec%0d_data", i), out_data8, vecs[i].dexp);
          chk($sformatf("vec%0d_tag", i), out_tag8, vecs[i].tag);
        end
        6: begin
          chk($sformatf("vec%0d_valid", i), out_valid6, 1);
          chk($sformatf("vec%0d_data", i), out_data6, vecs[i].dexp);
          chk($sformatf("vec%0d_tag", i), out_tag6, vecs[i].tag);
        end
        default: begin
          chk($sformatf("vec%0d_latency", i), out_valid4, 0);
          tick();
          chk($sformatf("vec%0d_valid", i), out_valid4, 1);
          chk($sformatf("vec%0d_data", i), out_data4, vecs[i].dexp);
          chk($sformatf("vec%0d_tag", i), out_tag4, vecs[i].tag);
        end
      endcase
      tick();
    end

    // Forward then inverse must restore the original state.
    for (int i = 0; i < 1000; i++) begin
      s = {$urandom(), $urandom(), $urandom(), $urandom()};
      send_recv(s, 1'b0, TAG_W'(i), f);
      send_recv(f, 1'b1, TAG_W'(i + 1), g);
      chk("identity", g, s);
    end

    // Backpressure: 8 tagged beats with random out_ready, then a looser random stream.
    stream(8, 50, 1'b1);
    stream(200, 60, 1'b0);
    out_ready = 1'b1;
    repeat (3) tick();

    // Clear with two beats in flight and a third presented.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inv    = 1'b0;
    in_data4  = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_tag    = 4'h9;
    tick();
    in_data4 = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_tag   = 4'hA;
    tick();
    chk("clear_pipe_full", in_ready4, 0);
    in_data4 = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_tag   = 4'hB;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear_out_valid", out_valid4, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("clear_flushed", out_valid4, 0);
    end
    s = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_recv(s, 1'b0, 4'hC, f);
    g = ref_shift(4, {128'b0, s}, 1'b0);
    chk("after_clear", f, g);

    // Asynchronous reset while an output beat is stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data4  = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_tag    = 4'hD;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("stall_before_reset", out_valid4, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid4, 0);
    chk("arst_out_data", out_data4, 0);
    chk("arst_out_tag", out_tag4, 0);
    chk("arst_in_ready", in_ready4, 1);
    q_data.delete();
    q_tag.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_held_valid", out_valid4, 0);
    rst_n = 1'b1;
    s = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_recv(s, 1'b1, 4'hE, f);
    g = ref_shift(4, {128'b0, s}, 1'b1);
    chk("after_reset", f, g);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
